obstacle_scheduler: RTL and testbench
=====================================

OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 The interface SHALL provide one clock; reset SHALL be asynchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 game_tick  input  2  per-clk strobes; [0] frame tick (motion and spawn), [1] slow tick (difficulty).
REQ-005 game_start_pulse  input  1  one-clk pulse from player controller; starts or restarts play.
REQ-006 game_over_pulse  input  1  one-clk pulse from player controller; freezes play.
REQ-007 obst0_x, obst1_x  output  8 each  slot horizontal position in pixels.
REQ-008 obst0_type, obst1_type  output  2 each  00 small cactus, 01 large cactus, 10 bird low, 11 bird high.
REQ-009 obst0_valid, obst1_valid  output  1 each  slot occupied.
REQ-010 speed  output  3  pixels moved per frame tick, range 1..4.
REQ-011 spawn_pulse  output  1  one-clk pulse in the cycle after a slot is loaded.
REQ-012 running  output  1  high in RUN state.

Function
REQ-013 FSM states SHALL be IDLE, RUN and HALT.
REQ-014 IDLE -> RUN on game_start_pulse; HALT -> RUN on game_start_pulse; RUN -> HALT on game_over_pulse; all other cycles hold state.
REQ-015 On any entry to RUN, the block SHALL clear both valid bits, set speed=1, load gap counter=MIN_GAP (24) and clear the difficulty counter, all in the same edge.
REQ-016 In RUN on game_tick[0], each valid slot SHALL update x <= x - speed; if x < speed, the slot SHALL instead clear valid with x held.
REQ-017 In RUN on game_tick[0], a nonzero gap counter SHALL decrement by 1.
REQ-018 In RUN on game_tick[0] with gap counter == 0 and a free slot, the block SHALL load that slot with x=SPAWN_X (200) and type=lfsr[1:0], reload gap=MIN_GAP+lfsr[6:2] (24..55), and assert spawn_pulse on the next cycle.
REQ-019 Both slots free -> slot 0 SHALL be loaded; no slot free -> spawn deferred, gap holds at 0, and the spawn retries on each later frame tick.
REQ-020 A slot freed and a spawn on the same tick: the freed slot SHALL be eligible for the spawn on that same tick.
REQ-021 In RUN on game_tick[1], the difficulty counter (6-bit) SHALL increment; on wrap 63->0 speed SHALL increment, saturating at 4.
REQ-022 game_over_pulse coincident with game_tick[0] SHALL take priority: no motion, spawn or gap update on that edge.
REQ-023 game_start_pulse in RUN SHALL be ignored; game_over_pulse in IDLE or HALT SHALL be ignored.
REQ-024 In HALT, slot x, type, valid and speed SHALL hold their values for display.
REQ-025 LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, SHALL advance every clk in all states, including IDLE and HALT.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 On reset the block SHALL enter IDLE with obst*_x=0, obst*_type=0, obst*_valid=0, speed=1, spawn_pulse=0, running=0, gap=MIN_GAP, difficulty=0 and LFSR=seed.
REQ-028 Reset asserted mid-RUN SHALL take effect immediately with no completion of a pending spawn or move.

Structure
REQ-029 A shared package dino_pkg SHALL hold the FSM state encoding, the obstacle type codes, SPAWN_X, MIN_GAP, MAX_SPEED and LFSR_SEED.
REQ-030 The LFSR SHALL be a sub-module lfsr16 with ports clk, reset, q[15:0].

Verification
REQ-031 Reset, then game_start_pulse, then 24 frame ticks -> spawn on tick 25: obst0_valid=1, obst0_x=200, spawn_pulse high for one clk, obst1_valid=0.
REQ-032 Slot 0 at x=200 with speed=1 over 200 frame ticks -> x reaches 0; next tick clears obst0_valid.
REQ-033 Both slots valid with gap reaching 0 -> no spawn while full, gap stays 0; first freeing tick spawns into the freed slot on that same tick.
REQ-034 64 slow ticks in RUN -> speed=2; 256 slow ticks -> speed=4; 320 slow ticks -> speed still 4.
REQ-035 game_over_pulse coincident with game_tick[0] -> state HALT, x/valid unchanged; then game_start_pulse -> RUN with both valid=0, speed=1.
REQ-036 Assert reset mid-RUN between clock edges -> all outputs at reset values before the next clk edge, state IDLE.

Source files
------------

// File: rtl/dino_pkg.sv
// Shared constants and encodings for the obstacle scheduler.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OBS_CACTUS_S = 2'b00,
    OBS_CACTUS_L = 2'b01,
    OBS_BIRD_LO  = 2'b10,
    OBS_BIRD_HI  = 2'b11
  } obst_type_e;

  localparam logic [7:0]  SPAWN_X   = 8'd200;
  localparam logic [5:0]  MIN_GAP   = 6'd24;
  localparam logic [2:0]  MAX_SPEED = 3'd4;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci step, taps 16,14,13,11 (bit indices 15,13,12,10), shifting left.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr16.sv
// Free-running 16-bit LFSR; advances every clock regardless of game state.
module lfsr16
  import dino_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= LFSR_SEED;
    else       q <= lfsr_next(q);
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Two-slot obstacle scheduler: spawns, scrolls and retires obstacles while running.
module obstacle_scheduler
  import dino_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] game_tick,
  input  logic       game_start_pulse,
  input  logic       game_over_pulse,
  output logic [7:0] obst0_x,
  output logic [7:0] obst1_x,
  output logic [1:0] obst0_type,
  output logic [1:0] obst1_type,
  output logic       obst0_valid,
  output logic       obst1_valid,
  output logic [2:0] speed,
  output logic       spawn_pulse,
  output logic       running
);

  state_e           state_q, state_d;
  logic [1:0][7:0]  x_q, x_d;
  logic [1:0][1:0]  type_q, type_d;
  logic [1:0]       valid_q, valid_d;
  logic [2:0]       speed_q, speed_d;
  logic [5:0]       gap_q, gap_d;
  logic [5:0]       diff_q, diff_d;
  logic             spawn_q, spawn_d;
  logic             running_q;
  logic             sel;
  logic [15:0]      lfsr_q;
  logic             unused_lfsr;

  lfsr16 u_lfsr (.clk(clk), .reset(reset), .q(lfsr_q));
  assign unused_lfsr = ^lfsr_q[15:7];

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_HALT: if (game_start_pulse) state_d = ST_RUN;
      ST_RUN:           if (game_over_pulse)  state_d = ST_HALT;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    x_d     = x_q;
    type_d  = type_q;
    valid_d = valid_q;
    speed_d = speed_q;
    gap_d   = gap_q;
    diff_d  = diff_q;
    spawn_d = 1'b0;
    sel     = 1'b0;
    if (state_q != ST_RUN && state_d == ST_RUN) begin
      valid_d = '0;
      speed_d = 3'd1;
      gap_d   = MIN_GAP;
      diff_d  = '0;
    end else if (state_q == ST_RUN && state_d == ST_RUN) begin
      if (game_tick[0]) begin
        for (int i = 0; i < 2; i++) begin
          if (valid_q[i]) begin
            if (x_q[i] < {5'd0, speed_q}) valid_d[i] = 1'b0;
            else                          x_d[i]     = x_q[i] - {5'd0, speed_q};
          end
        end
        // Spawn looks at post-motion occupancy so a slot freed this tick is reusable.
        if (gap_q != '0) begin
          gap_d = gap_q - 6'd1;
        end else if (!(valid_d[0] && valid_d[1])) begin
          sel          = valid_d[0];
          x_d[sel]     = SPAWN_X;
          type_d[sel]  = lfsr_q[1:0];
          valid_d[sel] = 1'b1;
          gap_d        = MIN_GAP + {1'b0, lfsr_q[6:2]};
          spawn_d      = 1'b1;
        end
      end
      if (game_tick[1]) begin
        diff_d = diff_q + 6'd1;
        if (diff_q == 6'd63 && speed_q < MAX_SPEED) speed_d = speed_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      type_q    <= '0;
      valid_q   <= '0;
      speed_q   <= 3'd1;
      gap_q     <= MIN_GAP;
      diff_q    <= '0;
      spawn_q   <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      type_q    <= type_d;
      valid_q   <= valid_d;
      speed_q   <= speed_d;
      gap_q     <= gap_d;
      diff_q    <= diff_d;
      spawn_q   <= spawn_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign obst0_x     = x_q[0];
  assign obst1_x     = x_q[1];
  assign obst0_type  = type_q[0];
  assign obst1_type  = type_q[1];
  assign obst0_valid = valid_q[0];
  assign obst1_valid = valid_q[1];
  assign speed       = speed_q;
  assign spawn_pulse = spawn_q;
  assign running     = running_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench: a behavioural game model pushes expected outputs each clock, a monitor compares.
module tb_obstacle_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] game_tick = 2'b00;
  logic       game_start_pulse = 1'b0;
  logic       game_over_pulse = 1'b0;
  logic [7:0] obst0_x, obst1_x;
  logic [1:0] obst0_type, obst1_type;
  logic       obst0_valid, obst1_valid;
  logic [2:0] speed;
  logic       spawn_pulse, running;

  obstacle_scheduler dut (
    .clk(clk), .reset(reset), .game_tick(game_tick),
    .game_start_pulse(game_start_pulse), .game_over_pulse(game_over_pulse),
    .obst0_x(obst0_x), .obst1_x(obst1_x),
    .obst0_type(obst0_type), .obst1_type(obst1_type),
    .obst0_valid(obst0_valid), .obst1_valid(obst1_valid),
    .speed(speed), .spawn_pulse(spawn_pulse), .running(running)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x0, x1;
    logic [1:0] t0, t1;
    logic       v0, v1;
    logic [2:0] spd;
    logic       sp, run;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: game state as plain integers (0 idle, 1 run, 2 halt).
  int          m_state, m_spd, m_gap, m_diff, m_free;
  int          mx[2], mt[2];
  bit          mv[2], m_spawn;
  logic [15:0] m_lfsr;
  int          r;
  exp_t        e;

  always @(posedge clk) begin
    if (reset) begin
      m_state = 0; m_spd = 1; m_gap = 24; m_diff = 0; m_spawn = 0;
      mx[0] = 0; mx[1] = 0; mt[0] = 0; mt[1] = 0; mv[0] = 0; mv[1] = 0;
      m_lfsr = 16'hACE1;
    end else begin
      r = int'(m_lfsr);
      m_spawn = 0;
      if (m_state != 1 && game_start_pulse) begin
        m_state = 1; mv[0] = 0; mv[1] = 0; m_spd = 1; m_gap = 24; m_diff = 0;
      end else if (m_state == 1 && game_over_pulse) begin
        m_state = 2;
      end else if (m_state == 1) begin
        if (game_tick[0]) begin
          for (int i = 0; i < 2; i++)
            if (mv[i]) begin
              if (mx[i] < m_spd) mv[i] = 0;
              else               mx[i] = mx[i] - m_spd;
            end
          if (m_gap > 0) m_gap = m_gap - 1;
          else begin
            m_free = !mv[0] ? 0 : (!mv[1] ? 1 : -1);
            if (m_free >= 0) begin
              mx[m_free] = 200; mt[m_free] = r % 4; mv[m_free] = 1;
              m_gap = 24 + (r / 4) % 32;
              m_spawn = 1;
            end
          end
        end
        if (game_tick[1]) begin
          m_diff = (m_diff + 1) % 64;
          if (m_diff == 0 && m_spd < 4) m_spd = m_spd + 1;
        end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    e.x0 = 8'(mx[0]); e.x1 = 8'(mx[1]);
    e.t0 = 2'(mt[0]); e.t1 = 2'(mt[1]);
    e.v0 = mv[0]; e.v1 = mv[1];
    e.spd = 3'(m_spd); e.sp = m_spawn; e.run = (m_state == 1);
    exp_q.push_back(e);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: actual=%0d required=%0d", nm, $time, act, req);
    end
  endtask

  // Monitor: negedge compares against the scoreboard; a reset rising while clk is
  // high is checked against reset values before the next active edge.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk or posedge reset);
      if (clk) begin
        #1;
        chk("async_rst_x0", 16'(obst0_x), 16'd0);
        chk("async_rst_x1", 16'(obst1_x), 16'd0);
        chk("async_rst_t0", 16'(obst0_type), 16'd0);
        chk("async_rst_t1", 16'(obst1_type), 16'd0);
        chk("async_rst_v0", 16'(obst0_valid), 16'd0);
        chk("async_rst_v1", 16'(obst1_valid), 16'd0);
        chk("async_rst_speed", 16'(speed), 16'd1);
        chk("async_rst_spawn", 16'(spawn_pulse), 16'd0);
        chk("async_rst_running", 16'(running), 16'd0);
      end else if (exp_q.size() == 0) begin
        if (!reset) chk("scoreboard_empty", 16'd1, 16'd0);
      end else begin
        x = exp_q.pop_front();
        if (!reset) begin
          chk("obst0_x", 16'(obst0_x), 16'(x.x0));
          chk("obst1_x", 16'(obst1_x), 16'(x.x1));
          chk("obst0_type", 16'(obst0_type), 16'(x.t0));
          chk("obst1_type", 16'(obst1_type), 16'(x.t1));
          chk("obst0_valid", 16'(obst0_valid), 16'(x.v0));
          chk("obst1_valid", 16'(obst1_valid), 16'(x.v1));
          chk("speed", 16'(speed), 16'(x.spd));
          chk("spawn_pulse", 16'(spawn_pulse), 16'(x.sp));
          chk("running", 16'(running), 16'(x.run));
        end
      end
    end
  end

  task automatic cyc(input bit f, input bit s, input bit st, input bit ov);
    @(posedge clk); #1;
    game_tick = {s, f};
    game_start_pulse = st;
    game_over_pulse = ov;
  endtask

  initial begin
    repeat (3) cyc(0, 0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    // Start, then 24 ticks drain the gap; tick 25 spawns into slot 0.
    cyc(0, 0, 1, 0);
    repeat (25) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    // Slot 0 scrolls to 0 and retires; slots fill and spawns defer meanwhile.
    repeat (240) cyc(1, 0, 0, 0);
    // Difficulty ramp: speed 2 at 64, 4 at 256, saturated through 320.
    repeat (320) cyc(0, 1, 0, 0);
    repeat (150) cyc(1, 0, 0, 0);
    // Game over coincident with a frame tick freezes; restart clears.
    cyc(1, 0, 0, 1);
    repeat (10) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    cyc(1, 0, 1, 0);
    repeat (5) cyc(1, 0, 1, 0);
    // Randomised play.
    repeat (4000)
      cyc(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 199) == 0), ($urandom_range(0, 299) == 0));
    // Asynchronous reset mid-run, between clock edges.
    cyc(0, 0, 1, 0);
    repeat (40) cyc(1, 0, 0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    game_tick = 2'b00; game_start_pulse = 1'b0; game_over_pulse = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc(0, 0, 1, 0);
    repeat (30) cyc(1, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0);
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
